arbitro_banco: RTL and testbench
================================

ARBITRO_BANCO -- requirements
Module: arbitro_banco

Interface
REQ-001 Parameters: none; all widths fixed (2 requesters, 4 registers x 8 bits, 2-bit address).
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  req[i]=1: requester i wants one bank access; held until ack[i].
REQ-005 wr  input  2  wr[i]=1 write, 0 read; sampled with req[i].
REQ-006 addr0, addr1  input  2 each  target register per requester.
REQ-007 wdata0, wdata1  input  8 each  write data per requester.
REQ-008 gnt  output  2  one-hot; gnt[i]=1 during the access cycle for requester i.
REQ-009 ack  output  2  one-hot, one-cycle pulse; access for requester i complete.
REQ-010 rdata  output  8  read result, valid while ack[i]=1 after a read; holds value otherwise.
REQ-011 banco_sinal  output  1  write enable to the register bank.
REQ-012 banco_registrador  output  2  register select to the bank.
REQ-013 banco_valorEscrita  output  8  write data to the bank.
REQ-014 banco_valorSaida  input  8  bank read data; bank updates it on negedge clock from banco_registrador.
REQ-015 colisoes  output  8  count of arbitrations where both req bits were 1.

Function
REQ-016 FSM states: OCIOSO, ACESSO, RESPOSTA; any other encoding goes to OCIOSO next cycle.
REQ-017 OCIOSO: if req!=0 at posedge, pick winner w, latch wr[w], addr_w, wdata_w, go ACESSO; else stay.
REQ-018 ACESSO: unconditionally go RESPOSTA at next posedge; RESPOSTA: unconditionally go OCIOSO.
REQ-019 req is sampled only in OCIOSO; changes in ACESSO/RESPOSTA are ignored.
REQ-020 gnt[w]=1 only in ACESSO; ack[w]=1 only in RESPOSTA; both 0 in OCIOSO; Moore outputs from registered state.
REQ-021 In ACESSO: banco_registrador=latched addr, banco_valorEscrita=latched wdata, banco_sinal=latched wr; banco_sinal=0 in every other state.
REQ-022 Read: at the posedge ending ACESSO, rdata <= banco_valorSaida; rdata unchanged on writes.
REQ-023 Latency: req sampled at edge N -> gnt after N, ack after N+1, OCIOSO after N+2; next grant earliest after N+3.
REQ-024 Arbitration: single req wins directly; both -> winner is requester not granted last (round robin); pointer ultimo updates on every grant.
REQ-025 colisoes increments by 1 on each OCIOSO grant with req==2'b11; saturates at 255, never wraps.
REQ-026 Outside ACESSO banco_registrador and banco_valorEscrita hold last driven values.

Reset
REQ-027 reset=0 forces immediately, independent of clock: state=OCIOSO, gnt=0, ack=0, rdata=0, banco_sinal=0, banco_registrador=0, banco_valorEscrita=0, colisoes=0, ultimo=1.
REQ-028 Reset during ACESSO aborts the access: banco_sinal drops before the next posedge, no ack issued.
REQ-029 First posedge after reset release samples req normally.

Configuration
REQ-030 Macro ARBITRO_PRIORIDADE_FIXA_EN defined: requester 0 always wins when both request; ultimo unused; colisoes still counts.
REQ-031 Macro undefined: round robin per REQ-024.

Verification
REQ-032 Write: req=01, wr=01, addr0=2, wdata0=0xA5 -> gnt=01 next cycle with banco_sinal=1, registrador=2; ack=01 following cycle.
REQ-033 Read-back: after REQ-032, req=10, wr=00, addr1=2 -> ack=10 with rdata=0xA5, banco_sinal=0 throughout.
REQ-034 Contention: req=11 held, each dropping req on own ack, then reasserted -> grants alternate 01,10,01,10; colisoes=1 per contended grant; with ARBITRO_PRIORIDADE_FIXA_EN, 01 always wins.
REQ-035 Saturation: 260 contended arbitrations -> colisoes=255.
REQ-036 Reset mid-access: assert reset=0 during ACESSO of a write to reg 3 -> banco_sinal=0 immediately, gnt=ack=0, rdata=0, no ack after release.

Source files
------------

// File: rtl/arbitro_banco.sv
// rtl/arbitro_banco.sv - two-requester arbiter in front of a 4x8 register bank
// Optional fixed priority (requester 0 wins on contention): ARBITRO_PRIORIDADE_FIXA_EN
module arbitro_banco (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic [1:0] req_i,
  input  logic [1:0] wr_i,
  input  logic [1:0] addr0_i,
  input  logic [1:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  input  logic [7:0] banco_valorSaida_i,
  output logic [1:0] gnt_o,
  output logic [1:0] ack_o,
  output logic [7:0] rdata_o,
  output logic       banco_sinal_o,
  output logic [1:0] banco_registrador_o,
  output logic [7:0] banco_valorEscrita_o,
  output logic [7:0] colisoes_o
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t    estado_q, estado_d;
  logic       venc_q, venc_d;
  logic       wr_q, wr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] colisoes_q, colisoes_d;
  logic       ultimo_q, ultimo_d;
  logic       venc;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic       sinal;

  // Winner for the current request pattern; only used when req_i != 0.
  always_comb begin
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    venc = ~req_i[0];
`else
    venc = (req_i == 2'b11) ? ~ultimo_q : req_i[1];
`endif
  end

  always_comb begin
    estado_d   = estado_q;
    venc_d     = venc_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    colisoes_d = colisoes_q;
    ultimo_d   = ultimo_q;
    gnt        = 2'b00;
    ack        = 2'b00;
    sinal      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (req_i != 2'b00) begin
          estado_d = ACESSO;
          venc_d   = venc;
          ultimo_d = venc;
          wr_d     = venc ? wr_i[1] : wr_i[0];
          addr_d   = venc ? addr1_i : addr0_i;
          wdata_d  = venc ? wdata1_i : wdata0_i;
          if (req_i == 2'b11 && colisoes_q != 8'hFF) begin
            colisoes_d = colisoes_q + 8'd1;
          end
        end
      end
      ACESSO: begin
        estado_d = RESPOSTA;
        gnt      = venc_q ? 2'b10 : 2'b01;
        sinal    = wr_q;
        if (!wr_q) begin
          rdata_d = banco_valorSaida_i;
        end
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
        ack      = venc_q ? 2'b10 : 2'b01;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q   <= OCIOSO;
      venc_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
      colisoes_q <= 8'd0;
      ultimo_q   <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      venc_q     <= venc_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      colisoes_q <= colisoes_d;
      ultimo_q   <= ultimo_d;
    end
  end

  // Address/data registers only change on a grant, so they hold between accesses.
  assign gnt_o                = gnt;
  assign ack_o                = ack;
  assign rdata_o              = rdata_q;
  assign banco_sinal_o        = sinal;
  assign banco_registrador_o  = addr_q;
  assign banco_valorEscrita_o = wdata_q;
  assign colisoes_o           = colisoes_q;

endmodule

// File: tb/tb_arbitro_banco.sv
// tb/tb_arbitro_banco.sv - self-checking bench for arbitro_banco with bank model
module tb_arbitro_banco;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req, wr, addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [7:0] valor_saida = 8'd0;
  logic [1:0] gnt, ack;
  logic [7:0] rdata;
  logic       banco_sinal;
  logic [1:0] banco_reg;
  logic [7:0] banco_wdata;
  logic [7:0] colisoes;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ack    = 0;
  logic [1:0] gnt_log[$];
  logic [7:0] mem[4];

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
  localparam bit FIXA = 1'b1;
`else
  localparam bit FIXA = 1'b0;
`endif

  arbitro_banco dut (
    .clock_i(clock), .reset_ni(reset_n), .req_i(req), .wr_i(wr),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .banco_valorSaida_i(valor_saida), .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata),
    .banco_sinal_o(banco_sinal), .banco_registrador_o(banco_reg),
    .banco_valorEscrita_o(banco_wdata), .colisoes_o(colisoes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  initial for (int i = 0; i < 4; i++) mem[i] = 8'd0;

  always @(negedge clock) valor_saida = mem[banco_reg];

  // Transaction-level model: phase 0 idle, 1 bank access, 2 response.
  int m_fase = 0, m_w = 0, m_last = 1, m_wr = 0, m_addr = 0, m_wdata = 0, m_rdata = 0, m_col = 0;

  always @(posedge clock) begin
    if (banco_sinal) mem[banco_reg] <= banco_wdata;
    if (!reset_n) begin
      m_fase = 0; m_w = 0; m_last = 1; m_wr = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_col = 0;
    end else if (m_fase == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) begin
          m_w   = FIXA ? 0 : 1 - m_last;
          m_col = (m_col >= 255) ? 255 : m_col + 1;
        end else m_w = (req == 2'b10) ? 1 : 0;
        m_last  = m_w;
        m_wr    = wr[m_w];
        m_addr  = (m_w == 1) ? addr1 : addr0;
        m_wdata = (m_w == 1) ? wdata1 : wdata0;
        m_fase  = 1;
      end
    end else if (m_fase == 1) begin
      if (m_wr == 0) m_rdata = mem[m_addr];
      m_fase = 2;
    end else m_fase = 0;
    #1;
    chk("gnt",        gnt,         (m_fase == 1) ? (1 << m_w) : 0);
    chk("ack",        ack,         (m_fase == 2) ? (1 << m_w) : 0);
    chk("sinal",      banco_sinal, (m_fase == 1 && m_wr == 1) ? 1 : 0);
    chk("registrador", banco_reg,  m_addr);
    chk("valorEscrita", banco_wdata, m_wdata);
    chk("rdata",      rdata,       m_rdata);
    chk("colisoes",   colisoes,    m_col);
    if (gnt != 2'b00) gnt_log.push_back(gnt);
    if (ack != 2'b00) n_ack++;
  end

  task automatic wait_ack(input int i, input string nm);
    bit ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clock); #2;
      if (ack[i]) ok = 1;
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic contend(input int n);
    logic [1:0] pend = 2'b00;
    int grants = 0;
    int guard  = 0;
    @(negedge clock);
    req = 2'b11; wr = 2'b00; addr0 = 2'd1; addr1 = 2'd2;
    while (grants < n && guard < n * 8 + 20) begin
      @(negedge clock);
      guard++;
      req  = req | pend;
      pend = 2'b00;
      if ((ack & req) != 2'b00) begin
        pend = ack & req;
        req  = req & ~ack;
        grants++;
      end
    end
    if (grants < n) chk("contend_timeout", grants, n);
    req = 2'b00;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int s;
    int acks0;
    reset_n = 1'b0; req = 0; wr = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_colisoes", colisoes, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Write 0xA5 into register 2 from requester 0.
    @(negedge clock);
    req = 2'b01; wr = 2'b01; addr0 = 2'd2; wdata0 = 8'hA5;
    @(posedge clock); #2;
    chk("wr_gnt", gnt, 2'b01);
    chk("wr_sinal", banco_sinal, 1);
    chk("wr_reg", banco_reg, 2);
    @(posedge clock); #2;
    chk("wr_ack", ack, 2'b01);
    @(negedge clock); req = 2'b00;

    // Read register 2 back through requester 1.
    @(negedge clock);
    req = 2'b10; wr = 2'b00; addr1 = 2'd2;
    @(posedge clock); #2;
    chk("rd_gnt", gnt, 2'b10);
    chk("rd_sinal", banco_sinal, 0);
    wait_ack(1, "rd_ack");
    chk("rd_ack", ack, 2'b10);
    chk("rd_rdata", rdata, 8'hA5);
    @(negedge clock); req = 2'b00;
    repeat (2) @(negedge clock);

    s = gnt_log.size();
    contend(4);
    for (int k = 0; k < 4; k++)
      chk("cont_gnt", (gnt_log.size() > s + k) ? gnt_log[s + k] : 0,
          FIXA ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10));
    chk("cont_colisoes", colisoes, 4);

    contend(260);
    chk("sat_colisoes", colisoes, 255);

    // Abort a write to register 3 with reset during the access cycle.
    @(negedge clock);
    req = 2'b01; wr = 2'b01; addr0 = 2'd3; wdata0 = 8'h5A;
    @(posedge clock); #2;
    chk("abort_gnt_pre", gnt, 2'b01);
    chk("abort_sinal_pre", banco_sinal, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_sinal", banco_sinal, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_ack", ack, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_colisoes", colisoes, 0);
    chk("abort_reg", banco_reg, 0);
    @(negedge clock); req = 2'b00;
    @(negedge clock); reset_n = 1'b1;
    acks0 = n_ack;
    repeat (6) @(negedge clock);
    chk("abort_no_ack", n_ack - acks0, 0);
    chk("abort_mem3", mem[3], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
